// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
// One request is outstanding at a time; memory answers with a single-cycle ack.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per instruction over a req/ack bus, with
// sign/zero-extended load return, lane-replicated stores and a timeout abort.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                funct3,
  input  logic [31:0]               ALUResult,
  input  logic [31:0]               ReadData2,
  output logic                      stall,
  output logic [31:0]               LoadData,
  output logic                      fault,
  output logic                      bus_error,
  load_store_unit_if.master         mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               legal, aligned, access_valid;
  logic [31:0]        store_wdata;
  logic [3:0]         store_wstrb;
  logic [31:0]        rdata_shifted;
  logic [31:0]        load_ext;

  // Unsigned loads exist only on the read side; stores stop at funct3 010.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = MemRead;
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (funct3[1:0])
      2'b10:   aligned = (ALUResult[1:0] == 2'b00);
      2'b01:   aligned = ~ALUResult[0];
      default: aligned = 1'b1;
    endcase
    access_valid = (MemRead ^ MemWrite) & legal & aligned;
  end

  always_comb begin
    store_wdata = ReadData2;
    store_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_wdata = {4{ReadData2[7:0]}};
        store_wstrb = 4'b0001 << ALUResult[1:0];
      end
      2'b01: begin
        store_wdata = {2{ReadData2[15:0]}};
        store_wstrb = 4'b0011 << ALUResult[1:0];
      end
      default: ;
    endcase
  end

  // Halfword accesses are aligned, so shifting by the byte lane also selects the half.
  always_comb begin
    rdata_shifted = mem.mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the async reset clears every register, including the captured access fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
      bus_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
      bus_error_q <= bus_error_d;
      cnt_q       <= cnt_d;
    end
  end

  // LoadData and bus_error are single-cycle pulses: they only hold a value in DONE.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    load_data_d = '0;
    bus_error_d = 1'b0;
    cnt_d       = '0;
    case (state_q)
      IDLE: begin
        if (access_valid) begin
          state_d  = WAIT;
          req_d    = 1'b1;
          we_d     = MemWrite;
          addr_d   = {ALUResult[31:2], 2'b00};
          wdata_d  = MemWrite ? store_wdata : 32'h0;
          wstrb_d  = MemWrite ? store_wstrb : 4'b0000;
          funct3_d = funct3;
          lane_d   = ALUResult[1:0];
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          state_d     = DONE;
          req_d       = 1'b0;
          load_data_d = we_q ? 32'h0 : load_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = DONE;
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    fault = 1'b0;
    case (state_q)
      IDLE: begin
        stall = access_valid;
        fault = (MemRead | MemWrite) & ~access_valid;
      end
      WAIT:    stall = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign LoadData      = load_data_q;
  assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and
// mid-access reset, each checked against hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, ReadData2;
  logic        stall, fault, bus_error;
  logic [31:0] LoadData;
  int          total = 0;
  int          bad = 0;
  int          sc;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .ReadData2 (ReadData2),
    .stall     (stall),
    .LoadData  (LoadData),
    .fault     (fault),
    .bus_error (bus_error),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an access in IDLE, waits `extra` WAIT cycles without ack, then acks.
  // Returns in the DONE cycle with the core inputs already released.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int extra, output int stall_cnt);
    stall_cnt = 0;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; ReadData2 = wd;
    #1;
    if (stall) stall_cnt++;
    step();
    repeat (extra) begin
      if (stall) stall_cnt++;
      step();
    end
    check("req_in_wait", bus.mem_req, 1);
    if (stall) stall_cnt++;
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    step();
    bus.mem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; ALUResult = '0; ReadData2 = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #12;
    check("rst_req",   bus.mem_req, 0);
    check("rst_addr",  bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_wstrb", bus.mem_wstrb, 4'b0000);
    check("rst_load",  LoadData, 32'h0);
    check("rst_berr",  bus_error, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
    step();

    // lb 0x1003, ack in the second WAIT cycle
    access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, sc);
    check("lb_stall_cycles", sc, 3);
    check("lb_done_stall",   stall, 0);
    check("lb_done_req",     bus.mem_req, 0);
    check("lb_data",         LoadData, 32'hFFFF_FF80);
    check("lb_addr",         bus.mem_addr, 32'h0000_1000);
    check("lb_wstrb",        bus.mem_wstrb, 4'b0000);
    check("lb_berr",         bus_error, 0);
    step();
    check("lb_after_data",   LoadData, 32'h0);

    access(1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, sc);
    check("lhu_data", LoadData, 32'h0000_80FF);
    step();
    access(1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, sc);
    check("lh_data", LoadData, 32'hFFFF_80FF);
    step();
    access(1, 0, 3'b100, 32'h0000_1001, 32'h0, 32'h80FF_1234, 0, sc);
    check("lbu_data", LoadData, 32'h0000_0012);
    step();
    access(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'h80FF_1234, 0, sc);
    check("lw_data", LoadData, 32'h80FF_1234);
    check("lw_addr", bus.mem_addr, 32'h0000_1004);
    step();

    // Stores: LoadData stays 0 even though rdata is non-zero on ack
    access(0, 1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'h5555_5555, 0, sc);
    check("sb_stall_cycles", sc, 2);
    check("sb_done_stall",   stall, 0);
    check("sb_we",           bus.mem_we, 1);
    check("sb_wdata",        bus.mem_wdata, 32'hABAB_ABAB);
    check("sb_wstrb",        bus.mem_wstrb, 4'b0010);
    check("sb_addr",         bus.mem_addr, 32'h0000_2000);
    check("sb_load",         LoadData, 32'h0);
    step();
    access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, sc);
    check("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb", bus.mem_wstrb, 4'b1100);
    step();
    access(0, 1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 0, sc);
    check("sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    check("sw_wstrb", bus.mem_wstrb, 4'b1111);
    step();

    // Faults: misaligned lw, both strobes set, store with unsigned funct3
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_1002;
    #1;
    check("lw_mis_fault", fault, 1);
    check("lw_mis_stall", stall, 0);
    step();
    check("lw_mis_req", bus.mem_req, 0);
    MemWrite = 1'b1; funct3 = 3'b000; ALUResult = 32'h0000_1000;
    #1;
    check("rw_fault", fault, 1);
    check("rw_stall", stall, 0);
    step();
    check("rw_req", bus.mem_req, 0);
    MemRead = 1'b0; funct3 = 3'b100;
    #1;
    check("sbu_fault", fault, 1);
    step();
    check("sbu_req", bus.mem_req, 0);
    MemWrite = 1'b0;
    #1;
    check("idle_fault", fault, 0);

    // Ack while idle must be ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.mem_ack = 1'b0;
    check("idle_ack_req",  bus.mem_req, 0);
    check("idle_ack_load", LoadData, 32'h0);

    // Timeout: four WAIT cycles without ack, then DONE with bus_error
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_3000; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_w%0d", i), bus.mem_req, 1);
      check($sformatf("to_stall_w%0d", i), stall, 1);
      step();
    end
    check("to_done_req",   bus.mem_req, 0);
    check("to_done_berr",  bus_error, 1);
    check("to_done_load",  LoadData, 32'h0);
    check("to_done_stall", stall, 0);
    MemRead = 1'b0;
    step();
    check("to_idle_berr",  bus_error, 0);
    check("to_idle_stall", stall, 0);

    // Reset in WAIT, late ack one cycle later
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_4000;
    step();
    check("rw_wait_req", bus.mem_req, 1);
    rst = 1'b1; MemRead = 1'b0;
    #1;
    check("rw_rst_req",   bus.mem_req, 0);
    check("rw_rst_addr",  bus.mem_addr, 32'h0);
    check("rw_rst_stall", stall, 0);
    step();
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
    step();
    bus.mem_ack = 1'b0;
    check("late_ack_req",   bus.mem_req, 0);
    check("late_ack_stall", stall, 0);
    check("late_ack_load",  LoadData, 32'h0);
    check("late_ack_berr",  bus_error, 0);
    step();
    check("late_ack_load2", LoadData, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
